skew_tr_buffer: RTL and testbench

Double-buffered, multi-lane transpose feeder for the systolic array edge. Accepts one LANES×DEPTH tile of signed operands per handshake and streams it out one column per beat. Lane l is skewed by l beats and zero-padded so the array receives a correctly diagonalised wavefront. Two tile banks let the next tile load while the current one drains, giving zero-bubble back-to-back tiles.

---
 rtl/skew_tr_pkg.sv | 27 ++
 rtl/skew_tr_bank.sv | 48 ++++
 rtl/skew_tr_buffer.sv | 235 +++++++++++++++++++++++
 tb/tb_skew_tr_buffer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/skew_tr_pkg.sv
// skew_tr_pkg: shared types and helpers for the skew/transpose tile buffer.
//   drain_state_e : drain FSM states (IDLE, DRAIN)
//   beats()       : beats per tile, L = DEPTH + LANES - 1 + PAD
//   beat_cnt_w()  : width of a counter able to hold 0..L
package skew_tr_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;

    localparam int DEF_LANES = 4;
    localparam int DEF_DEPTH = 8;
    localparam int DEF_BITS  = 8;
    localparam int DEF_PAD   = 0;

    function automatic int beats(input int depth, input int lanes, input int pad);
        return depth + lanes - 1 + pad;
    endfunction

    function automatic int beat_cnt_w(input int l);
        return $clog2(l + 1);
    endfunction

    localparam int DEF_BEAT_W = beat_cnt_w(beats(DEF_DEPTH, DEF_LANES, DEF_PAD));

endpackage

// File: rtl/skew_tr_bank.sv
// skew_tr_bank: one tile bank of the skew/transpose buffer.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears the stored tile)
//   load_i    : capture tile_i into the bank
//   tile_i    : LANES x DEPTH x BITS tile, tile_i[l][k] = lane l element k
//   t_i       : beat index to read
//   col_o     : skewed column for beat t_i; lane l shows element t_i-l,
//               or zero when that index falls outside 0..DEPTH-1
module skew_tr_bank
    import skew_tr_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int DEPTH = DEF_DEPTH,
    parameter int BITS  = DEF_BITS,
    parameter int CW    = DEF_BEAT_W
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  load_i,
    input  logic [LANES-1:0][DEPTH-1:0][BITS-1:0] tile_i,
    input  logic [CW-1:0]                         t_i,
    output logic [LANES-1:0][BITS-1:0]            col_o
);

    logic [LANES-1:0][DEPTH-1:0][BITS-1:0] tile_q;

    // Tile storage: whole-tile parallel load.
    always_ff @(posedge clk) begin
        if (rst) begin
            tile_q <= '0;
        end else if (load_i) begin
            tile_q <= tile_i;
        end
    end

    // Skewed column read: lane l lags the tile by l beats, zero outside its window.
    always_comb begin
        col_o = '0;
        for (int l = 0; l < LANES; l++) begin
            if ((int'(t_i) >= l) && ((int'(t_i) - l) < DEPTH)) begin
                col_o[l] = tile_q[l][int'(t_i) - l];
            end else begin
                col_o[l] = '0;
            end
        end
    end

endmodule

// File: rtl/skew_tr_buffer.sv
// skew_tr_buffer: double-buffered skew/transpose feeder for a systolic array edge.
// Accepts one LANES x DEPTH tile per handshake and streams it one skewed
// column per beat (L = DEPTH + LANES - 1 + PAD beats per tile).
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : tile handshake; in_ready depends on registered state only
//   in_data               : in_data[l][k] = lane l element k (k=0 emitted first)
//   out_valid/out_ready   : beat handshake
//   out_data              : one skewed column, zero when out_valid is low
//   out_first, out_last   : beat 0 / beat L-1 of a tile
//   busy                  : at least one bank holds a tile
module skew_tr_buffer
    import skew_tr_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int DEPTH = DEF_DEPTH,
    parameter int BITS  = DEF_BITS,
    parameter int PAD   = DEF_PAD
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [LANES-1:0][DEPTH-1:0][BITS-1:0] in_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [LANES-1:0][BITS-1:0]            out_data,
    output logic                                  out_first,
    output logic                                  out_last,
    output logic                                  busy
);

    localparam int L  = beats(DEPTH, LANES, PAD);
    localparam int CW = beat_cnt_w(L);
    localparam logic [CW-1:0] LAST_BEAT = CW'(L - 1);

    typedef logic [LANES-1:0][BITS-1:0] col_t;

    drain_state_e state_q, state_d;
    logic [CW-1:0] beat_q, beat_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic [1:0]    count_q, count_d;
    logic          in_ready_q;
    logic          out_valid_q, out_valid_d;
    logic          out_first_q, out_first_d;
    logic          out_last_q, out_last_d;
    col_t          out_data_q, out_data_d;

    logic          accept_s;
    logic          fire_s;
    logic          last_fire_s;
    logic [CW-1:0] t0_s, t1_s;
    col_t          col0_s, col1_s;
    col_t          rd_col_s, oth_col_s, byp_col_s;

    assign accept_s    = in_valid & in_ready_q;
    assign fire_s      = out_valid_q & out_ready;
    assign last_fire_s = fire_s & (beat_q == LAST_BEAT);

    // Read index per bank: the draining bank looks one beat ahead so the
    // output register can be refilled on a fire; the other bank looks at beat 0.
    always_comb begin
        t0_s = '0;
        t1_s = '0;
        if (state_q == DRAIN) begin
            if (rd_ptr_q) begin
                t1_s = beat_q + CW'(1);
            end else begin
                t0_s = beat_q + CW'(1);
            end
        end else begin
            t0_s = '0;
            t1_s = '0;
        end
    end

    skew_tr_bank #(.LANES(LANES), .DEPTH(DEPTH), .BITS(BITS), .CW(CW)) u_bank0 (
        .clk    (clk),
        .rst    (rst),
        .load_i (accept_s & ~wr_ptr_q),
        .tile_i (in_data),
        .t_i    (t0_s),
        .col_o  (col0_s)
    );

    skew_tr_bank #(.LANES(LANES), .DEPTH(DEPTH), .BITS(BITS), .CW(CW)) u_bank1 (
        .clk    (clk),
        .rst    (rst),
        .load_i (accept_s & wr_ptr_q),
        .tile_i (in_data),
        .t_i    (t1_s),
        .col_o  (col1_s)
    );

    // Column sources: current bank, the other bank, and beat 0 of the tile on
    // in_data (only lane 0 is non-zero at beat 0), the latter so a tile loaded
    // this cycle can be presented next cycle without waiting for the bank write.
    always_comb begin
        byp_col_s    = '0;
        byp_col_s[0] = in_data[0][0];
        if (rd_ptr_q) begin
            rd_col_s  = col1_s;
            oth_col_s = col0_s;
        end else begin
            rd_col_s  = col0_s;
            oth_col_s = col1_s;
        end
    end

    // Occupancy and bank pointers.
    always_comb begin
        case ({accept_s, last_fire_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (accept_s) begin
            wr_ptr_d = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (last_fire_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Drain FSM next state and next output beat; outputs hold unless a beat fires.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        out_valid_d = out_valid_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d     = DRAIN;
                    beat_d      = '0;
                    out_valid_d = 1'b1;
                    out_first_d = 1'b1;
                    out_last_d  = (LAST_BEAT == '0);
                    out_data_d  = byp_col_s;
                end else if (count_q != 2'd0) begin
                    state_d     = DRAIN;
                    beat_d      = '0;
                    out_valid_d = 1'b1;
                    out_first_d = 1'b1;
                    out_last_d  = (LAST_BEAT == '0);
                    out_data_d  = rd_col_s;
                end else begin
                    out_valid_d = 1'b0;
                    out_first_d = 1'b0;
                    out_last_d  = 1'b0;
                    out_data_d  = '0;
                end
            end
            DRAIN: begin
                if (last_fire_s) begin
                    if (count_q == 2'd2) begin
                        beat_d      = '0;
                        out_first_d = 1'b1;
                        out_last_d  = (LAST_BEAT == '0);
                        out_data_d  = oth_col_s;
                    end else if (accept_s) begin
                        beat_d      = '0;
                        out_first_d = 1'b1;
                        out_last_d  = (LAST_BEAT == '0);
                        out_data_d  = byp_col_s;
                    end else begin
                        state_d     = IDLE;
                        beat_d      = '0;
                        out_valid_d = 1'b0;
                        out_first_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_data_d  = '0;
                    end
                end else if (fire_s) begin
                    beat_d      = beat_q + CW'(1);
                    out_first_d = 1'b0;
                    out_last_d  = ((beat_q + CW'(1)) == LAST_BEAT);
                    out_data_d  = rd_col_s;
                end else begin
                    beat_d = beat_q;
                end
            end
            default: begin
                state_d     = IDLE;
                beat_d      = '0;
                out_valid_d = 1'b0;
                out_first_d = 1'b0;
                out_last_d  = 1'b0;
                out_data_d  = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= (count_d != 2'd2);
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign busy      = (count_q != 2'd0);

endmodule

// File: tb/tb_skew_tr_buffer.sv
// Self-checking bench for skew_tr_buffer: a 2x3 (PAD=1) instance driven by a
// constant vector table, hand sequences and random traffic against a
// tile-queue reference model, plus a 1x1 instance for the single-beat case.
module tb_skew_tr_buffer;

    localparam int LN = 2;
    localparam int DP = 3;
    localparam int BT = 8;
    localparam int PD = 1;
    localparam int L0 = DP + LN - 1 + PD;

    typedef logic [LN-1:0][DP-1:0][BT-1:0] tile_t;
    typedef logic [LN-1:0][BT-1:0]         col_t;

    logic  clk = 1'b0;
    logic  rst;
    logic  in_valid, in_ready, out_valid, out_ready, out_first, out_last, busy;
    tile_t in_data;
    col_t  out_data;

    logic                    in_valid1, in_ready1, out_valid1, out_ready1;
    logic                    out_first1, out_last1, busy1;
    logic [0:0][0:0][BT-1:0] in_data1;
    logic [0:0][BT-1:0]      out_data1;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: queue of accepted tiles, beat position in head tile
    tile_t mq[$];
    int    mpos    = 0;
    bit    m_rdy   = 1'b0;
    int    m_fired = 0;

    always #5 clk = ~clk;

    skew_tr_buffer #(.LANES(LN), .DEPTH(DP), .BITS(BT), .PAD(PD)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_first(out_first), .out_last(out_last), .busy(busy)
    );

    skew_tr_buffer #(.LANES(1), .DEPTH(1), .BITS(BT), .PAD(0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_data(out_data1), .out_first(out_first1), .out_last(out_last1), .busy(busy1)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic tile_t mk_tile(input int a0, input int a1, input int a2,
                                      input int b0, input int b1, input int b2);
        tile_t t;
        logic [31:0] v;
        v = a0; t[0][0] = v[7:0];
        v = a1; t[0][1] = v[7:0];
        v = a2; t[0][2] = v[7:0];
        v = b0; t[1][0] = v[7:0];
        v = b1; t[1][1] = v[7:0];
        v = b2; t[1][2] = v[7:0];
        return t;
    endfunction

    function automatic col_t mk_col(input int e0, input int e1);
        col_t c;
        logic [31:0] v;
        v = e0; c[0] = v[7:0];
        v = e1; c[1] = v[7:0];
        return c;
    endfunction

    // beat p of a tile: lane l carries element p-l when that index exists
    function automatic col_t exp_col(input tile_t t, input int p);
        col_t c;
        c = '0;
        for (int l = 0; l < LN; l++) begin
            if ((p - l) >= 0 && (p - l) < DP) c[l] = t[l][p - l];
        end
        return c;
    endfunction

    function automatic tile_t rnd_tile();
        tile_t t;
        logic [31:0] r;
        for (int l = 0; l < LN; l++) begin
            for (int k = 0; k < DP; k++) begin
                r = $urandom;
                t[l][k] = r[7:0];
            end
        end
        return t;
    endfunction

    // one clock of the main DUT with full comparison against the model
    task automatic cycle(input logic v, input tile_t t, input logic r, input logic rs,
                         output bit acc);
        bit    fire;
        bit    ev;
        logic  pv;
        col_t  pd;
        col_t  ec;
        pv   = out_valid;
        pd   = out_data;
        acc  = v && !rs && m_rdy;
        fire = r && !rs && (mq.size() != 0);
        in_valid  = v;
        in_data   = t;
        out_ready = r;
        rst       = rs;
        @(posedge clk);
        #1;
        if (rs) begin
            mq.delete();
            mpos  = 0;
            m_rdy = 1'b0;
        end else begin
            if (fire) begin
                m_fired++;
                mpos++;
                if (mpos == L0) begin
                    void'(mq.pop_front());
                    mpos = 0;
                end
            end
            if (acc) mq.push_back(t);
            m_rdy = (mq.size() != 2);
        end
        ev = (mq.size() != 0);
        ec = ev ? exp_col(mq[0], mpos) : '0;
        chk("out_valid", 64'(out_valid), 64'(ev));
        chk("in_ready",  64'(in_ready),  64'(m_rdy));
        chk("busy",      64'(busy),      64'(ev));
        chk("out_first", 64'(out_first), 64'(ev && mpos == 0));
        chk("out_last",  64'(out_last),  64'(ev && mpos == L0 - 1));
        chk("out_data",  64'(out_data),  64'(ec));
        if (pv && !r && !rs) chk("stall_hold", 64'(out_data), 64'(pd));
    endtask

    task automatic drain_all();
        bit a;
        for (int i = 0; i < 40 && mq.size() != 0; i++) cycle(1'b0, '0, 1'b1, 1'b0, a);
        chk("drain_timeout", 64'(mq.size()), 64'd0);
    endtask

    typedef struct {
        logic vin; int sel; logic ordy;
        logic ev; int e0; int e1; logic ef; logic el; logic er; logic eb;
    } vec_t;

    vec_t  tbl[11];
    tile_t ta, tb, tc;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit a;
        bit got;
        int fired0;
        ta = mk_tile(1, 2, 3, 4, 5, 6);
        tb = mk_tile(-1, -2, -3, -4, -5, -6);
        tc = mk_tile(7, 8, 9, 10, 11, 12);
        in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b1;

        // two back-to-back tiles, out_ready held high: 10 contiguous beats
        tbl[0]  = '{1'b1, 0, 1'b1, 1'b1,  1,  0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[1]  = '{1'b1, 1, 1'b1, 1'b1,  2,  4, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 0, 1'b1, 1'b1,  3,  5, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 0, 1'b1, 1'b1,  0,  6, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 0, 1'b1, 1'b1,  0,  0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 0, 1'b1, 1'b1, -1,  0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 0, 1'b1, 1'b1, -2, -4, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 0, 1'b1, 1'b1, -3, -5, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 0, 1'b1, 1'b1,  0, -6, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 0, 1'b1, 1'b1,  0,  0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 0, 1'b1, 1'b0,  0,  0, 1'b0, 1'b0, 1'b1, 1'b0};

        // reset, then release
        for (int i = 0; i < 3; i++) cycle(1'b1, ta, 1'b1, 1'b1, a);
        cycle(1'b0, '0, 1'b1, 1'b0, a);

        for (int i = 0; i < 11; i++) begin
            in_valid  = tbl[i].vin;
            in_data   = (tbl[i].sel != 0) ? tb : ta;
            out_ready = tbl[i].ordy;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].ev));
            chk($sformatf("tbl%0d_data", i),  64'(out_data),  64'(mk_col(tbl[i].e0, tbl[i].e1)));
            chk($sformatf("tbl%0d_first", i), 64'(out_first), 64'(tbl[i].ef));
            chk($sformatf("tbl%0d_last", i),  64'(out_last),  64'(tbl[i].el));
            chk($sformatf("tbl%0d_ready", i), 64'(in_ready),  64'(tbl[i].er));
            chk($sformatf("tbl%0d_busy", i),  64'(busy),      64'(tbl[i].eb));
        end
        in_valid = 1'b0;

        // out_ready toggling during drain: every beat held while stalled, none lost
        fired0 = m_fired;
        cycle(1'b1, ta, 1'b1, 1'b0, a);
        for (int i = 0; i < 16; i++) cycle(1'b0, '0, (i % 2) != 0, 1'b0, a);
        drain_all();
        chk("stall_beats", 64'(m_fired - fired0), 64'(L0));

        // both banks full, third tile waits with in_valid held
        cycle(1'b1, ta, 1'b1, 1'b0, a);
        cycle(1'b1, tb, 1'b1, 1'b0, a);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) cycle(1'b1, tc, 1'b1, 1'b0, got);
        chk("third_accept", 64'(got), 64'd1);
        drain_all();

        // reset at beat 2 with second bank full
        cycle(1'b1, ta, 1'b1, 1'b0, a);
        cycle(1'b1, tb, 1'b1, 1'b0, a);
        cycle(1'b0, '0, 1'b1, 1'b0, a);
        cycle(1'b1, tc, 1'b1, 1'b1, a);
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0, a);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 2) != 0, rnd_tile(), ($urandom % 10) < 7, 1'b0, a);
        end
        drain_all();

        // 1x1 instance: single beat is first and last; back-to-back has no gap
        in_valid1 = 1'b1; in_data1[0][0] = 8'h80; out_ready1 = 1'b1;
        @(posedge clk); #1;
        chk("one_valid", 64'(out_valid1), 64'd1);
        chk("one_data",  64'(out_data1),  64'h80);
        chk("one_first", 64'(out_first1), 64'd1);
        chk("one_last",  64'(out_last1),  64'd1);
        chk("one_ready", 64'(in_ready1),  64'd1);
        in_data1[0][0] = 8'h7f;
        @(posedge clk); #1;
        chk("one_b2b_valid", 64'(out_valid1), 64'd1);
        chk("one_b2b_data",  64'(out_data1),  64'h7f);
        chk("one_b2b_first", 64'(out_first1), 64'd1);
        chk("one_b2b_busy",  64'(busy1),      64'd1);
        in_valid1 = 1'b0; out_ready1 = 1'b0;
        @(posedge clk); #1;
        chk("one_stall_data", 64'(out_data1), 64'h7f);
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        chk("one_end_valid", 64'(out_valid1), 64'd0);
        chk("one_end_data",  64'(out_data1),  64'd0);
        chk("one_end_busy",  64'(busy1),      64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
